// File: rtl/perm_round_ctrl.sv
// Round sequencer for an iterative Keccak-f[1600] core: holds the 5x5x64 state,
// feeds it to an external round datapath and steps the round index.
module perm_round_ctrl #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0][4:0][63:0]   state_in,
  input  logic                    abort,
  output logic [4:0][4:0][63:0]   rnd_state_o,
  input  logic [4:0][4:0][63:0]   rnd_state_i,
  output logic [31:0]             perm_num,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0][4:0][63:0]   state_out,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  ctrl_state_t           ctrl_q, ctrl_d;
  logic [4:0]            round_q, round_d;
  logic [4:0][4:0][63:0] state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  // abort outranks every other transition; the state register keeps its value on abort
  always_comb begin
    ctrl_d  = ctrl_q;
    round_d = round_q;
    state_d = state_q;
    case (ctrl_q)
      IDLE: begin
        if (!abort && in_valid) begin
          state_d = state_in;
          round_d = '0;
          ctrl_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          round_d = '0;
          ctrl_d  = IDLE;
        end else begin
          state_d = rnd_state_i;
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            ctrl_d  = DONE;
          end else begin
            round_d = round_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          ctrl_d = IDLE;
        end
      end
      default: begin
        ctrl_d = IDLE;
      end
    endcase
  end

  assign in_ready    = (ctrl_q == IDLE);
  assign busy        = (ctrl_q == RUN);
  assign out_valid   = (ctrl_q == DONE);
  assign perm_num    = busy ? {27'd0, round_q} : 32'd0;
  assign rnd_state_o = state_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Self-checking bench for perm_round_ctrl with a behavioural Keccak round attached
// as the external datapath and a per-cycle reference model.
module tb_perm_round_ctrl;

  typedef logic [4:0][4:0][63:0] kstate_t;
  typedef enum int {M_IDLE, M_RUN, M_DONE} model_phase_t;

  localparam int NR = 24;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [31:0] perm_num;
  kstate_t     state_in;
  kstate_t     rnd_state_o;
  kstate_t     rnd_state_i;
  kstate_t     state_out;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 0;

  model_phase_t m_phase;
  int           m_round;
  kstate_t      m_state;

  perm_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .abort      (abort),
    .rnd_state_o(rnd_state_o),
    .rnd_state_i(rnd_state_i),
    .perm_num   (perm_num),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic bit rc_bit(input int t);
    logic [8:0] r;
    r = 9'd1;
    for (int i = 1; i <= t % 255; i++) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h171;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] round_const(input int ir);
    logic [63:0] rc;
    rc = '0;
    for (int j = 0; j < 7; j++) rc[(1 << j) - 1] = rc_bit(j + 7 * ir);
    return rc;
  endfunction

  // rho offsets generated by walking the (x,y) -> (y,2x+3y) orbit
  function automatic int rho_off(input int x, input int y);
    int cx, cy, nx;
    if (x == 0 && y == 0) return 0;
    cx = 1;
    cy = 0;
    for (int t = 0; t < 24; t++) begin
      if (cx == x && cy == y) return ((t + 1) * (t + 2) / 2) % 64;
      nx = cy;
      cy = (2 * cx + 3 * cy) % 5;
      cx = nx;
    end
    return 0;
  endfunction

  function automatic kstate_t keccak_round(input kstate_t a_in, input int ir);
    kstate_t          a, b;
    logic [4:0][63:0] c, d;
    a = a_in;
    b = '0;
    for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
    for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ d[x];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) b[y][(2 * x + 3 * y) % 5] = rotl(a[x][y], rho_off(x, y));
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
    a[0][0] = a[0][0] ^ round_const(ir);
    return a;
  endfunction

  function automatic kstate_t keccak_perm(input kstate_t a_in, input int n);
    kstate_t a;
    a = a_in;
    for (int r = 0; r < n; r++) a = keccak_round(a, r);
    return a;
  endfunction

  function automatic kstate_t pattern(input logic [63:0] seed);
    kstate_t p;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) p[x][y] = (seed * 64'(5 * x + y + 1)) ^ {32'(x), 32'(y)};
    return p;
  endfunction

  assign rnd_state_i = keccak_round(rnd_state_o, int'(perm_num[4:0]));

  // Reference model: one permutation = accept, NR round cycles, then hold until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= M_IDLE;
      m_round <= 0;
      m_state <= '0;
    end else begin
      case (m_phase)
        M_IDLE: if (!abort && in_valid) begin
          m_state <= state_in;
          m_round <= 0;
          m_phase <= M_RUN;
        end
        M_RUN: if (abort) begin
          m_round <= 0;
          m_phase <= M_IDLE;
        end else begin
          m_state <= keccak_round(m_state, m_round);
          if (m_round == NR - 1) begin
            m_round <= 0;
            m_phase <= M_DONE;
          end else begin
            m_round <= m_round + 1;
          end
        end
        M_DONE: if (abort || out_ready) m_phase <= M_IDLE;
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input kstate_t got, input kstate_t exp);
    bit reported;
    checks++;
    if (got !== exp) begin
      errors++;
      reported = 0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          if (!reported && got[x][y] !== exp[x][y]) begin
            reported = 1;
            $display("[TB] FAIL %s lane[%0d][%0d] got %h expected %h at %0t",
                     name, x, y, got[x][y], exp[x][y], $time);
          end
    end
  endtask

  task automatic checkOutput();
    check_bit("in_ready", in_ready, m_phase == M_IDLE);
    check_bit("busy", busy, m_phase == M_RUN);
    check_bit("out_valid", out_valid, m_phase == M_DONE);
    check_val("perm_num", 64'(perm_num), (m_phase == M_RUN) ? 64'(m_round) : 64'd0);
    check_state("state_out", state_out, m_state);
    check_state("rnd_state_o", rnd_state_o, m_state);
  endtask

  always @(negedge clk) if (cmp_en) checkOutput();

  task automatic applyStimulus(input logic iv, input kstate_t st, input logic ab, input logic ordy);
    in_valid  = iv;
    state_in  = st;
    abort     = ab;
    out_ready = ordy;
  endtask

  task automatic start_perm(input kstate_t st);
    @(negedge clk);
    check_bit("ready_before_accept", in_ready, 1'b1);
    #1 applyStimulus(1'b1, st, 1'b0, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, st, 1'b0, 1'b0);
  endtask

  task automatic run_to_done(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        check_val("perm_num_seq", 64'(perm_num), 64'(lat));
        lat++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout got no out_valid expected out_valid within 40 cycles");
    end
    check_val("perm_num_done", 64'(perm_num), 64'd0);
  endtask

  task automatic wait_round(input int r);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy && perm_num == 32'(r)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wait_round got no round %0d expected round %0d within 40 cycles", r, r);
    end
  endtask

  task automatic release_done();
    @(negedge clk);
    #1 applyStimulus(1'b0, state_in, 1'b0, 1'b1);
    @(posedge clk);
    #1 applyStimulus(1'b0, state_in, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("release_in_ready", in_ready, 1'b1);
    check_bit("release_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    kstate_t st1, st2, captured;
    int      lat;
    int      hits[$];

    st1 = pattern(64'h9E3779B97F4A7C15);
    st2 = pattern(64'h0123456789ABCDEF);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Model pins: round constants and rho offsets against known values
    check_val("rc_round1", round_const(1), 64'h0000000000008082);
    check_val("rc_round23", round_const(23), 64'h8000000080008008);
    check_val("rho_3_4", 64'(rho_off(3, 4)), 64'd56);

    #1 rst_n = 1'b0;
    #1;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_val("rst_perm_num", 64'(perm_num), 64'd0);
    check_state("rst_state", state_out, '0);

    // Accept on the very first edge after release
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cmp_en = 1;
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, 1'b0, 1'b0);
    run_to_done(lat);
    check_val("latency_zero", 64'(lat), 64'd24);
    check_val("zero_lane00", state_out[0][0], 64'hF1258F7940E1DDE7);
    check_state("zero_perm", state_out, keccak_perm('0, NR));

    // Downstream stall holds the result
    captured = state_out;
    repeat (10) begin
      @(negedge clk);
      check_bit("stall_valid", out_valid, 1'b1);
      check_state("stall_hold", state_out, captured);
    end
    release_done();

    // Abort at round 7 leaves the register frozen and drops straight to idle
    start_perm(st1);
    wait_round(7);
    captured = state_out;
    #1 applyStimulus(1'b0, st1, 1'b1, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, st1, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_state("abort_hold", state_out, captured);
    check_state("abort_round7", captured, keccak_perm(st1, 7));
    repeat (5) begin
      @(negedge clk);
      check_bit("abort_no_valid", out_valid, 1'b0);
    end

    start_perm(st2);
    run_to_done(lat);
    check_val("latency_after_abort", 64'(lat), 64'd24);
    check_state("perm_st2", state_out, keccak_perm(st2, NR));
    release_done();

    // Abort beats in_valid in idle
    captured = state_out;
    @(negedge clk);
    #1 applyStimulus(1'b1, st1, 1'b1, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, st1, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("idle_abort_busy", busy, 1'b0);
    check_state("idle_abort_hold", state_out, captured);

    // Abort beats out_ready=0 in done
    start_perm(st1);
    run_to_done(lat);
    #1 applyStimulus(1'b0, st1, 1'b1, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, st1, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("done_abort_ready", in_ready, 1'b1);
    check_bit("done_abort_valid", out_valid, 1'b0);

    // Asynchronous reset at round 12
    start_perm(st2);
    wait_round(12);
    #2 rst_n = 1'b0;
    #1;
    check_bit("mid_rst_in_ready", in_ready, 1'b1);
    check_bit("mid_rst_out_valid", out_valid, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_perm_num", 64'(perm_num), 64'd0);
    check_state("mid_rst_state", state_out, '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check_bit("post_rst_no_valid", out_valid, 1'b0);
    end

    // Continuous streaming: one accept every 26 cycles
    @(negedge clk);
    #1 applyStimulus(1'b1, st1, 1'b0, 1'b1);
    for (int n = 0; n < 110; n++) begin
      @(negedge clk);
      if (in_ready) hits.push_back(n);
    end
    check_val("stream_accepts", 64'(hits.size()), 64'd4);
    for (int i = 1; i < hits.size(); i++)
      check_val("stream_period", 64'(hits[i] - hits[i-1]), 64'd26);
    #1 applyStimulus(1'b0, st1, 1'b0, 1'b1);
    begin
      bit idle_seen;
      idle_seen = 0;
      for (int i = 0; i < 40 && !idle_seen; i++) begin
        @(negedge clk);
        if (in_ready) idle_seen = 1;
      end
      check_bit("stream_drain_idle", idle_seen, 1'b1);
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
